// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and FSM encoding for the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry fetch FIFO of {instr, pc, misaligned}
module fetch_buffer #(
  parameter int unsigned  W           = 65,
  parameter logic [W-1:0] RESET_ENTRY = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop, wr_sel;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0) && !clear_i;
    do_push  = push_i && (clear_i || (count_q != 2'd2) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_sel   = wr_ptr_q;
    if (clear_i) begin
      // a push alongside clear becomes the sole entry, in slot 0
      rd_ptr_d = 1'b0;
      wr_sel   = 1'b0;
      wr_ptr_d = do_push;
      count_d  = {1'b0, do_push};
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= RESET_ENTRY;
      mem_q[1] <= RESET_ENTRY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_sel] <= data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch: owns the PC, single-outstanding imem requests, 2-entry buffer
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter int unsigned         IWIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned         BUF_DEPTH = 2
) (
  input  logic                f_clk,
  input  logic                f_rst,
  output logic [PC_WIDTH-1:0] f_o_iaddr,
  output logic                f_o_stb,
  input  logic                f_i_ack,
  input  logic [IWIDTH-1:0]   f_i_inst,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic                f_o_ce,
  output logic                f_o_misaligned,
  input  logic                f_i_stall,
  input  logic                f_i_flush,
  input  logic                f_i_change_pc,
  input  logic [PC_WIDTH-1:0] f_i_new_pc
);

  localparam int unsigned EW    = IWIDTH + PC_WIDTH + 1;
  localparam logic [1:0]  DEPTH = 2'(BUF_DEPTH);
  localparam logic [EW-1:0] RESET_ENTRY = {IWIDTH'(NOP_INSTR), {PC_WIDTH{1'b0}}, 1'b0};

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                stale_q, stale_d;
  logic                outst_q, outst_d;
  logic                stb;
  logic                buf_push, buf_pop, buf_clear;
  logic [EW-1:0]       buf_din, buf_head;
  logic [1:0]          buf_count;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stale_d   = stale_q;
    outst_d   = outst_q;
    stb       = 1'b0;
    buf_push  = 1'b0;
    buf_clear = 1'b0;
    buf_din   = {f_i_inst, pc_q, 1'b0};

    if (f_i_ack && outst_q) begin
      outst_d = 1'b0;
      stale_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if ((buf_count + {1'b0, outst_q}) < DEPTH) begin
          stb     = 1'b1;
          outst_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (f_i_ack) begin
          state_d = S_REQ;
          if (!stale_q) begin
            buf_push = 1'b1;
            pc_d     = pc_q + PC_WIDTH'(PC_STEP);
          end
        end
      end
      S_HALT: state_d = S_HALT;
    endcase

    // Redirect outranks flush; neither issues a request in the same cycle.
    if (f_i_change_pc || f_i_flush) begin
      buf_clear = 1'b1;
      buf_push  = 1'b0;
      stb       = 1'b0;
      pc_d      = pc_q;
      outst_d   = outst_q && !f_i_ack;
      stale_d   = outst_d;
      state_d   = S_HALT;
      if (f_i_change_pc) begin
        pc_d = f_i_new_pc;
        if (is_misaligned(f_i_new_pc[1:0])) begin
          buf_push = 1'b1;
          buf_din  = {IWIDTH'(NOP_INSTR), f_i_new_pc, 1'b1};
        end else begin
          state_d = outst_d ? S_WAIT : S_REQ;
        end
      end
    end
  end

  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stale_q <= 1'b0;
      outst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      outst_q <= outst_d;
    end
  end

  fetch_buffer #(
    .W           (EW),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_buf (
    .clk_i   (f_clk),
    .rst_i   (f_rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .clear_i (buf_clear),
    .data_i  (buf_din),
    .count_o (buf_count),
    .head_o  (buf_head)
  );

  assign f_o_ce         = (buf_count != 2'd0) && !f_i_flush && !f_i_change_pc;
  assign buf_pop        = f_o_ce && !f_i_stall;
  assign f_o_stb        = stb;
  assign f_o_iaddr      = pc_q;
  assign f_o_instr      = buf_head[EW-1 -: IWIDTH];
  assign f_o_pc         = buf_head[PC_WIDTH:1];
  assign f_o_misaligned = buf_head[0];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the 5-stage RV32I core. It sits directly upstream of the decoder. It owns the PC, issues single-outstanding requests to instruction memory, and buffers returned words in a 2-entry queue. It presents {instr, pc, ce} to the decoder under stall/flush/redirect control.

Parameters:
PC_WIDTH, 32, program counter and instruction address width
IWIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, fetch buffer entries (fixed at 2; other values unsupported)

Ports:
f_clk  input  1  clock, all state on rising edge
f_rst  input  1  asynchronous active-high reset
f_o_iaddr  output  PC_WIDTH  instruction memory request address
f_o_stb  output  1  request strobe, one cycle per request
f_i_ack  input  1  response valid, at least 1 cycle after stb
f_i_inst  input  IWIDTH  response data, valid with f_i_ack
f_o_instr  output  IWIDTH  instruction to decoder (buffer head)
f_o_pc  output  PC_WIDTH  PC of f_o_instr
f_o_ce  output  1  head valid, decoder clock-enable
f_o_misaligned  output  1  head entry carries misaligned-PC fault
f_i_stall  input  1  decoder stall, holds head
f_i_flush  input  1  flush, drop buffer and in-flight fetch, halt
f_i_change_pc  input  1  redirect request (branch/jump/trap)
f_i_new_pc  input  PC_WIDTH  redirect target

Behaviour:
- Reset is asynchronous and active-high. While f_rst=1:
  - f_o_stb=0, f_o_iaddr=RESET_PC, f_o_ce=0, f_o_misaligned=0
  - f_o_pc=0, f_o_instr=32'h0000_0013 (NOP)
  - buffer empty, stale=0, state=S_IDLE
- FSM states:
  - S_IDLE: first cycle after reset release; goes to S_REQ.
  - S_REQ: asserts f_o_stb with f_o_iaddr=pc, but only if count+outstanding<2; otherwise stays with stb=0. Goes to S_WAIT once stb is issued.
  - S_WAIT: waits for f_i_ack.
    - Non-stale ack: push {f_i_inst, pc, 0}, pc<=pc+4 (wraps modulo 2^PC_WIDTH), go to S_REQ.
    - Stale ack: discarded, stale<=0, go to S_REQ.
  - S_HALT: no requests issued; leaves only on f_i_change_pc.
- Requests: at most one outstanding. f_o_iaddr is held stable from stb until ack.
- Best-case throughput: one instruction every 2 cycles; back-to-back stb is not allowed.
- Buffer pop occurs when f_o_ce=1 and f_i_stall=0. Push and pop may happen in the same cycle; count is then unchanged.
- Buffer full (count=2): no new stb. An ack can never arrive while full, because the issue rule prevents it.
- Output timing: f_o_instr/f_o_pc/f_o_misaligned show the head entry and are registered. f_o_ce=(count!=0) and is forced to 0 in any cycle where f_i_flush or f_i_change_pc is high.
- Redirect (f_i_change_pc=1):
  - Buffer is cleared and pc<=f_i_new_pc.
  - An outstanding request is marked stale. An ack in the same cycle as the redirect is discarded.
  - Next state is S_REQ, or S_WAIT(stale) if a request is still outstanding.
  - Redirect takes priority over flush, stall and push.
- Misaligned target (f_i_new_pc[1:0]!=0):
  - No memory request is made.
  - One entry {NOP, f_i_new_pc, misaligned=1} is pushed, then the stage enters S_HALT.
- Flush alone (f_i_flush=1, f_i_change_pc=0):
  - Buffer is cleared, the outstanding request is marked stale, and the stage enters S_HALT.
  - pc is unchanged. Fetch waits for the trap-vector redirect.
- Stall: holds the head entry. Fetching continues until the buffer is full.
- Latency from reset release to first instruction:
  - Cycle 1: stb is high with RESET_PC.
  - Cycle k: ack arrives.
  - Cycle k+1: f_o_ce=1.

Decomposition:
- Shared header (existing .vh): NOP encoding, FSM state encodings (S_IDLE, S_REQ, S_WAIT, S_HALT), and the PC increment constant 4.
- Sub-module fetch_buffer: 2-entry FIFO of {instr, pc, misaligned} with push, pop, clear, count and head outputs, plus async active-high reset.

Test Plan:
1. Reset release; memory acks 1 cycle after each stb with inst=addr^32'hA5A5A5A5 -> PCs 0,4,8,12 delivered in order, stb never in consecutive cycles, f_o_ce first high at cycle 3.
2. Hold f_i_stall=1 for 10 cycles after the first entry -> at most 2 stb issued, buffer count=2, f_o_instr/f_o_pc stable; release -> PCs 0,4,8 consecutive, no loss or duplication.
3. f_i_change_pc=1, new_pc=32'h100 while a request to 0x8 is outstanding; its ack arrives the next cycle -> ack dropped, next stb addr=0x100, f_o_pc sequence 0x100,0x104.
4. f_i_change_pc=1 in the same cycle as f_i_ack -> ack discarded, buffer empty, f_o_ce=0 that cycle.
5. f_i_flush=1 alone -> buffer empty, no stb for 20 cycles; then change_pc to 0x200 -> fetch resumes at 0x200.
6. change_pc to 32'h102 -> no stb, single entry with pc=0x102, misaligned=1, instr=NOP, then halt. Also, PC at 32'hFFFF_FFFC increments to 0.
